// File: rtl/core_pkg.sv
// Shared core types for the write-back stage: source-select and load-size
// encodings plus the default datapath width.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_CSR = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10,
    LD_D = 2'b11
  } ld_size_e;

endpackage

// File: rtl/wb_stage_p_if.sv
// MEM/WB boundary bundle: the MEM-stage capture signals and the register-file
// write port with its forwarding tap. The stage itself uses the slave modport.
interface wb_stage_p_if
  import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = 5
);
    localparam int OFS_W = $clog2(XLEN / 8);

    logic              in_valid;
    logic              flush;
    logic              ctl_regwrite_in;
    wb_sel_e           wb_sel_in;
    ld_size_e          ld_size_in;
    logic              ld_unsigned_in;
    logic [OFS_W-1:0]  addr_lo_in;
    logic [REG_AW-1:0] rd_in;
    logic [XLEN-1:0]   alu_result_in;
    logic [XLEN-1:0]   mem_rdata_in;
    logic [XLEN-1:0]   pc_plus4_in;
    logic [XLEN-1:0]   csr_rdata_in;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [XLEN-1:0]   fwd_data;
    logic              retire;

    modport master (
        output in_valid, flush, ctl_regwrite_in, wb_sel_in, ld_size_in,
               ld_unsigned_in, addr_lo_in, rd_in, alu_result_in,
               mem_rdata_in, pc_plus4_in, csr_rdata_in,
        input  rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, retire
    );

    modport slave (
        input  in_valid, flush, ctl_regwrite_in, wb_sel_in, ld_size_in,
               ld_unsigned_in, addr_lo_in, rd_in, alu_result_in,
               mem_rdata_in, pc_plus4_in, csr_rdata_in,
        output rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, retire
    );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load extractor: picks the addressed byte/half/word/double lane
// of the memory word and zero- or sign-extends it to XLEN.
module wb_load_align
  import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0]              mem_rdata,
    input  logic [$clog2(XLEN/8)-1:0]    addr_lo,
    input  ld_size_e                     ld_size,
    input  logic                         ld_unsigned,
    output logic [XLEN-1:0]              result
);
    localparam int OFS_W = $clog2(XLEN / 8);
    localparam int SH_W  = $clog2(XLEN);

    // Offset masks drop the sub-lane address bits; for XLEN=32 the word mask
    // is zero, so word and double both read the full lane 0.
    localparam logic [OFS_W-1:0] MASK_B = '1;
    localparam logic [OFS_W-1:0] MASK_H = ~OFS_W'(1);
    localparam logic [OFS_W-1:0] MASK_W = ~OFS_W'(3);
    localparam logic [OFS_W-1:0] MASK_D = '0;

    logic [OFS_W-1:0] ofs_mask;
    logic [OFS_W-1:0] byte_ofs;
    logic [SH_W-1:0]  shamt;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  keep_mask;
    logic             sign_bit;
    int               nbits;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        ofs_mask = MASK_D;
        nbits    = XLEN;
        unique case (ld_size)
            LD_B: begin ofs_mask = MASK_B; nbits = 8;  end
            LD_H: begin ofs_mask = MASK_H; nbits = 16; end
            LD_W: begin ofs_mask = MASK_W; nbits = 32; end
            LD_D: begin ofs_mask = MASK_D; nbits = XLEN; end
        endcase

        byte_ofs  = addr_lo & ofs_mask;
        shamt     = {byte_ofs, 3'b000};
        shifted   = mem_rdata >> shamt;
        // A full-width load overflows the shift to zero, giving an all-ones
        // mask and no extension bits, so ld_unsigned has no effect there.
        keep_mask = (XLEN'(1) << nbits) - XLEN'(1);
        sign_bit  = shifted[nbits-1];
        result    = (shifted & keep_mask)
                  | ((!ld_unsigned && sign_bit) ? ~keep_mask : '0);
    end

endmodule

// File: rtl/wb_stage_p.sv
// MEM/WB pipeline register, write-back source select and register-file port.
// Optional instret counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage_p
  import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_stage_p_if.slave bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0] instret_out,
    input  logic        instret_clr
`endif
);
    logic [XLEN-1:0]   load_val;
    logic [XLEN-1:0]   wdata_d;
    logic              capture;

    logic              valid_q;
    logic              regwrite_q;
    logic [REG_AW-1:0] rd_q;
    logic [XLEN-1:0]   wdata_q;

    wb_load_align #(.XLEN(XLEN)) u_align (
        .mem_rdata   (bus.mem_rdata_in),
        .addr_lo     (bus.addr_lo_in),
        .ld_size     (bus.ld_size_in),
        .ld_unsigned (bus.ld_unsigned_in),
        .result      (load_val)
    );

    always_comb begin
        wdata_d = bus.alu_result_in;
        unique case (bus.wb_sel_in)
            WB_ALU: wdata_d = bus.alu_result_in;
            WB_MEM: wdata_d = load_val;
            WB_PC4: wdata_d = bus.pc_plus4_in;
            WB_CSR: wdata_d = bus.csr_rdata_in;
        endcase
    end

    assign capture = bus.in_valid & ~bus.flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else begin
            valid_q <= capture;
            if (capture) begin
                regwrite_q <= bus.ctl_regwrite_in;
                rd_q       <= bus.rd_in;
                wdata_q    <= wdata_d;
            end
        end
    end

    // x0 is hard-wired zero, so a write to it is suppressed here.
    assign bus.rf_we     = valid_q & regwrite_q & (rd_q != '0);
    assign bus.rf_waddr  = rd_q;
    assign bus.rf_wdata  = wdata_q;
    assign bus.fwd_valid = bus.rf_we;
    assign bus.fwd_rd    = bus.rf_waddr;
    assign bus.fwd_data  = bus.rf_wdata;
    assign bus.retire    = valid_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (instret_clr) begin
            instret_q <= '0;
        end else if (valid_q) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_out = instret_q;
`endif

endmodule
